delay_line_prober: RTL and testbench

Latency-measurement front end for the selectable delay lines. Drives a single-cycle marker byte into a delay path, watches the path's output for that marker, and reports the round-trip latency in clock cycles. It sits on the input side of the delay line, with the line's output looped back to it. This lets firmware and test equipment confirm which tap (30/45/60/90 stages) is selected and that the line is intact.

---
 rtl/delay_line_prober.sv | 153 +++++++++++++++
 tb/tb_delay_line_prober.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/delay_line_prober.sv
// delay_line_prober
//
// Latency-measurement front end for a selectable delay line. On an accepted
// start it flushes the line with IDLE_VAL, then drives the latched marker for
// a single cycle. It then counts cycles until that marker comes back on
// echo_in, or until MAX_WAIT cycles have passed.
//
// Ports:
//   clk        in   1      single clock, rising edge
//   rst        in   1      synchronous, active-high reset
//   start      in   1      measurement request, sampled every cycle
//   marker     in   WIDTH  probe value, latched when start is accepted
//   probe_out  out  WIDTH  registered drive into the delay line
//   echo_in    in   WIDTH  delay line output (looped back)
//   busy       out  1      registered, high while a measurement runs
//   done       out  1      registered one-cycle end-of-measurement pulse
//   timeout    out  1      registered, pulses with done when no echo was seen
//   latency    out  CNT_W  registered result, held until the next done

module delay_line_prober #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      CNT_W     = 8,
  parameter int unsigned      MAX_WAIT  = 200,
  parameter int unsigned      FLUSH_CYC = 96,
  parameter logic [WIDTH-1:0] IDLE_VAL  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] marker,
  output logic [WIDTH-1:0] probe_out,
  input  logic [WIDTH-1:0] echo_in,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] latency
);

  localparam logic [CNT_W-1:0] MaxCnt    = CNT_W'(MAX_WAIT);
  // The counter runs 0..FLUSH_CYC-1 while flushing, giving FLUSH_CYC cycles.
  localparam logic [CNT_W-1:0] FlushLast = CNT_W'(FLUSH_CYC - 1);
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

  typedef enum logic [1:0] {
    StIdle,
    StFlush,
    StSend,
    StWait
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] marker_q, marker_d;
  logic [WIDTH-1:0] probe_q, probe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] latency_q, latency_d;

  logic             echo_match;

  // Raw comparison; only acted upon in StSend and StWait.
  assign echo_match = (echo_in == marker_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    marker_d  = marker_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    latency_d = latency_q;

    unique case (state_q)
      StIdle: begin
        // A marker equal to IDLE_VAL could never be told apart from the
        // flush pattern, so such a request is dropped.
        if (start && (marker != IDLE_VAL)) begin
          marker_d = marker;
          cnt_d    = '0;
          state_d  = StFlush;
        end
      end

      StFlush: begin
        if (cnt_q == FlushLast) begin
          cnt_d   = '0;
          state_d = StSend;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      StSend, StWait: begin
        if (echo_match) begin
          // A match at the limit still counts as a match.
          latency_d = cnt_q;
          done_d    = 1'b1;
          cnt_d     = '0;
          state_d   = StIdle;
        end else if (cnt_q == MaxCnt) begin
          latency_d = MaxCnt;
          done_d    = 1'b1;
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = StIdle;
        end else begin
          // Stops at MaxCnt, so the counter can never wrap.
          cnt_d   = cnt_q + CntOne;
          state_d = StWait;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase

    // Outputs are registered from the next state, so they line up with the
    // state they describe.
    busy_d  = (state_d != StIdle);
    probe_d = (state_d == StSend) ? marker_q : IDLE_VAL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      marker_q  <= IDLE_VAL;
      probe_q   <= IDLE_VAL;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      latency_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      marker_q  <= marker_d;
      probe_q   <= probe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      latency_q <= latency_d;
    end
  end

  assign probe_out = probe_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign latency   = latency_q;

endmodule

// File: tb/tb_delay_line_prober.sv
// Directed bench for delay_line_prober. A behavioural delay line (registered
// taps, combinational loopback, or a dead line tied to zero) closes the loop.
// Cycle numbers follow the timing description: cycle 0 is the cycle in which
// start is high, and done for an N-stage line is expected in cycle 98+N.

module tb_delay_line_prober;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] marker;
  logic [7:0] probe_out;
  logic [7:0] echo_in;
  logic       busy;
  logic       done;
  logic       timeout;
  logic [7:0] latency;

  int n_checks = 0;
  int n_fail   = 0;

  // Delay line model: hist[i] is probe_out delayed by i+1 cycles.
  logic [7:0] hist [0:255];
  int         tap  = 30;
  int         mode = 0;  // 0 registered line, 1 combinational, 2 dead line

  int         done_cnt = 0;
  logic [7:0] last_sent = 8'h00;

  delay_line_prober dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .marker    (marker),
    .probe_out (probe_out),
    .echo_in   (echo_in),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout),
    .latency   (latency)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    hist[0] <= probe_out;
    for (int i = 1; i < 256; i++) hist[i] <= hist[i-1];
  end

  always_comb begin
    echo_in = 8'h00;
    case (mode)
      0:       echo_in = hist[tap-1];
      1:       echo_in = probe_out;
      default: echo_in = 8'h00;
    endcase
  end

  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (probe_out != 8'h00) last_sent <= probe_out;
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after an edge (cycle 0). Returns the cycle in which done was
  // seen, or the limit if it never came. Ignored starts are injected at
  // cycles inj_a / inj_b (0 disables) with markers 8'h3C / 8'h77.
  task automatic run_meas(input logic [7:0] m, input int inj_a, input int inj_b,
                          output int cyc, output int to, output int lat,
                          output int busy1, output int busy_end);
    start  = 1'b1;
    marker = m;
    step();
    start  = 1'b0;
    cyc    = 1;
    busy1  = int'(busy);
    while (!done && cyc < 400) begin
      if (cyc == inj_a) begin
        start = 1'b1; marker = 8'h3C;
      end else if (cyc == inj_b) begin
        start = 1'b1; marker = 8'h77;
      end else begin
        start = 1'b0;
      end
      step();
      cyc++;
    end
    start    = 1'b0;
    to       = int'(timeout);
    lat      = int'(latency);
    busy_end = int'(busy);
  endtask

  int cyc, to, lat, b1, be, dc;

  initial begin
    for (int i = 0; i < 256; i++) hist[i] = 8'h00;
    rst = 1'b1; start = 1'b0; marker = 8'h00;
    repeat (3) step();
    check_eq("reset_probe", int'(probe_out), 0);
    check_eq("reset_busy", int'(busy), 0);
    check_eq("reset_done", int'(done), 0);
    check_eq("reset_timeout", int'(timeout), 0);
    check_eq("reset_latency", int'(latency), 0);
    rst = 1'b0;
    repeat (2) step();

    // 30-stage line
    mode = 0; tap = 30;
    run_meas(8'hA5, 0, 0, cyc, to, lat, b1, be);
    check_eq("t30_cycle", cyc, 128);
    check_eq("t30_latency", lat, 30);
    check_eq("t30_timeout", to, 0);
    check_eq("t30_busy_c1", b1, 1);
    check_eq("t30_busy_done", be, 0);

    // Tap switching, second start in the done cycle
    repeat (5) step();
    tap = 45;
    run_meas(8'h5A, 0, 0, cyc, to, lat, b1, be);
    check_eq("t45_cycle", cyc, 143);
    check_eq("t45_latency", lat, 45);
    tap = 90;
    run_meas(8'h5A, 0, 0, cyc, to, lat, b1, be);
    check_eq("t90_cycle", cyc, 188);
    check_eq("t90_latency", lat, 90);
    check_eq("t90_timeout", to, 0);

    // Combinational loopback
    repeat (5) step();
    mode = 1;
    run_meas(8'hA5, 0, 0, cyc, to, lat, b1, be);
    check_eq("comb_cycle", cyc, 98);
    check_eq("comb_latency", lat, 0);
    check_eq("comb_timeout", to, 0);

    // Dead line
    repeat (5) step();
    mode = 2;
    run_meas(8'hA5, 0, 0, cyc, to, lat, b1, be);
    check_eq("dead_cycle", cyc, 298);
    check_eq("dead_latency", lat, 200);
    check_eq("dead_timeout", to, 1);
    step();
    check_eq("dead_timeout_pulse", int'(timeout), 0);

    // Starts while busy are ignored (one in FLUSH, one in WAIT)
    repeat (5) step();
    mode = 0; tap = 30;
    dc = done_cnt;
    run_meas(8'hC3, 10, 110, cyc, to, lat, b1, be);
    check_eq("ign_cycle", cyc, 128);
    check_eq("ign_latency", lat, 30);
    check_eq("ign_sent_marker", int'(last_sent), 'hC3);
    repeat (150) step();
    check_eq("ign_done_count", done_cnt - dc, 1);

    // Start with marker == IDLE_VAL is dropped
    dc = done_cnt;
    start = 1'b1; marker = 8'h00;
    step();
    start = 1'b0;
    check_eq("idle_marker_busy", int'(busy), 0);
    repeat (120) step();
    check_eq("idle_marker_done", done_cnt - dc, 0);

    // Reset during WAIT at count 10 (cycle 96+1+10)
    start = 1'b1; marker = 8'hA5;
    step();
    start = 1'b0;
    cyc = 1;
    while (cyc < 107) begin
      step();
      cyc++;
    end
    check_eq("rst_busy_before", int'(busy), 1);
    dc = done_cnt;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_probe", int'(probe_out), 0);
    check_eq("rst_latency", int'(latency), 0);
    check_eq("rst_done", int'(done), 0);
    repeat (60) step();
    check_eq("rst_no_done", done_cnt - dc, 0);
    run_meas(8'hA5, 0, 0, cyc, to, lat, b1, be);
    check_eq("post_rst_cycle", cyc, 128);
    check_eq("post_rst_latency", lat, 30);

    // Echo exactly at count == MAX_WAIT
    repeat (5) step();
    tap = 200;
    run_meas(8'h81, 0, 0, cyc, to, lat, b1, be);
    check_eq("edge_cycle", cyc, 298);
    check_eq("edge_latency", lat, 200);
    check_eq("edge_timeout", to, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
